rx_fsrc_sample_packer: RTL
==========================

Name: rx_fsrc_sample_packer

Overview:
Next-generation RX FSRC invalid-sample remover. It strips every sample equal to a programmable marker and packs the surviving samples, in order, into full-width output beats through a residue buffer. Output beats are always dense unless explicitly flushed. Adds AXI-style backpressure, flush with marker padding, and a saturating drop counter. Sits between the FSRC RX datapath and the downstream DMA/packer.

Parameters:
DATA_WIDTH, 512, beat width in bits; must be a multiple of NP.
NP, 16, sample width in bits.
NS, DATA_WIDTH/NP, samples per beat; derived, not overridable.
CNT_W, 32, drop counter width.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
fsrc_en  in  1  1 = remove/pack; 0 = bypass
marker  in  NP  invalid-sample code; quasi-static, change only while fsrc_en=0
in_data  in  DATA_WIDTH  input beat; sample i = bits [i*NP +: NP]
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
out_data  out  DATA_WIDTH  packed output beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
flush  in  1  single-cycle request to emit partial residue
flush_busy  out  1  flush pending
drop_clr  in  1  synchronous clear of drop_count
drop_count  out  CNT_W  saturating count of removed samples

Behaviour:
- Reset (resetn=0, async): out_valid=0, out_data=0, flush_busy=0, drop_count=0, S1 empty, buffer level=0. in_ready=0 during reset.
- Bypass (fsrc_en=0): out_data=in_data, out_valid=in_valid, in_ready=out_ready, all combinational. S1, buffer and flush_busy are cleared synchronously every cycle. drop_count holds.
- Pipeline (fsrc_en=1):
  - S1: on accept, register the beat and the NS-bit mask (sample==marker).
  - Compaction: combinational from S1. Valid samples shift to the low indices in original order. k = NS - popcount(mask).
  - Buffer: 2*NS samples, level L in 0..2*NS-1. S1 advances when L<NS or an output beat fires this cycle. The k samples are written at position L (post-pop). L_next = L - (fire ? NS : 0) + k.
  - in_ready = !s1_valid || s1_advance.
  - out_valid is registered: high iff L>=NS, or a flush beat is presented. out_data = buffer[0..NS-1]. On fire the buffer shifts down by NS.
  - Latency: first output 2 cycles after accept of a beat with NS valid samples, when out_ready=1. Sustained throughput is 1 beat/cycle when no samples are removed.
- Invalid beats: a beat with all NS samples invalid advances S1 with k=0, is counted, and writes nothing.
- Flush: sets flush_busy.
  - When S1 is empty and 0<L<NS, present one beat with samples L..NS-1 padded with marker, then L=0 and flush_busy clears.
  - If L=0 at that point, flush_busy clears with no beat.
  - While flush_busy=1, in_ready=0.
  - Flush during an active output stall waits for the fire.
- drop_count: adds popcount(mask) on each S1 advance and saturates at all-ones. drop_clr has priority over the increment in the same cycle.
- out_data/out_valid must hold stable while out_valid && !out_ready.
- A fsrc_en 1->0 transition mid-operation discards the residue; no beat is emitted.

Decomposition:
- Package rx_fsrc_pkg: sample_t (logic [NP-1:0]), the NS derivation, and a popcount function.
- Sub-module rx_fsrc_compactor: combinational mask+data -> left-packed samples plus count k. It is reusable by the TX side.

Test Plan (DATA_WIDTH=64, NP=16, NS=4, marker=16'h8000):
- Beats {A0..A3} then {B0..B3}, none invalid, out_ready=1 -> out beats identical, first out_valid 2 cycles after accept, back-to-back, drop_count=0.
- Beats [A0,8000,A2,A3], [8000,B1,8000,B3], [C0,C1,C2,C3] -> outputs [A0,A2,A3,B1], [B3,C0,C1,C2]; residue L=1 (C3); drop_count=3.
- Residue C3 then flush -> one beat [C3,8000,8000,8000], flush_busy drops the cycle after the fire, L=0.
- out_ready=0 for 6 cycles with continuous valid input -> in_ready falls and out_data stays stable; no sample is lost or duplicated after release.
- Beat of four 8000 samples -> no output, drop_count+=4. Force drop_count to all-ones minus 1, then send this beat -> saturates at all-ones. drop_clr concurrent with the beat -> 0.
- fsrc_en=0 -> out mirrors in combinationally. resetn asserted mid-stream -> out_valid=0 immediately and residue lost.

Source files
------------

// File: rtl/rx_fsrc_pkg.sv
// Shared types and helpers for the FSRC sample packer/compactor.
// Pure declarations: no logic, no latency, no flow control.
package rx_fsrc_pkg;

   localparam int SAMPLE_W = 16;
   localparam int MAX_NS   = 256;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      FL_IDLE,
      FL_DRAIN,
      FL_BEAT
   } fl_st_e;

   function automatic int samples_per_beat(input int dw, input int np);
      return dw / np;
   endfunction

   function automatic int unsigned popcount(input logic [MAX_NS-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < MAX_NS; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rx_fsrc_compactor.sv
// Left-packs the unmasked samples of a beat in original order and reports how many survive.
// Purely combinational; no flow control.
module rx_fsrc_compactor
   import rx_fsrc_pkg::*;
#(
   parameter int NS = 32,
   parameter int NP = 16
) (
   input  logic [NS*NP-1:0]         data_i,
   input  logic [NS-1:0]            mask_i,
   output logic [NS*NP-1:0]         data_o,
   output logic [$clog2(NS+1)-1:0]  k_o
);

   localparam int KW = $clog2(NS+1);

   int idx;

   // Unused upper lanes stay zero so the caller can OR the result into a wider buffer.
   always_comb begin
      data_o = '0;
      idx    = 0;
      for (int i = 0; i < NS; i++) begin
         if (!mask_i[i]) begin
            data_o[idx*NP +: NP] = data_i[i*NP +: NP];
            idx = idx + 1;
         end
      end
   end

   assign k_o = KW'(NS - int'(popcount(MAX_NS'(mask_i))));

endmodule

// File: rtl/rx_fsrc_sample_packer.sv
// Strips marker samples and repacks survivors into dense beats; 2-cycle latency, 1 beat/cycle.
// Stalls S1 (in_ready low) when the residue buffer holds a full beat that cannot leave.
module rx_fsrc_sample_packer
   import rx_fsrc_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int NP         = 16,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  fsrc_en,
   input  logic [NP-1:0]         marker,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  flush,
   output logic                  flush_busy,
   input  logic                  drop_clr,
   output logic [CNT_W-1:0]      drop_count
);

   localparam int NS = samples_per_beat(DATA_WIDTH, NP);
   localparam int KW = $clog2(NS+1);
   localparam int LW = $clog2(2*NS);
   localparam int BW = 2*DATA_WIDTH;
   localparam logic [LW-1:0] NS_L = LW'(NS);

   logic                  s1_vld_q;
   logic [DATA_WIDTH-1:0] s1_dat_q;
   logic [NS-1:0]         s1_msk_q;
   logic [BW-1:0]         buf_q;
   logic [LW-1:0]         lvl_q;
   logic                  out_vld_q;
   fl_st_e                fl_st_q;
   logic                  fl_busy_q;
   logic [CNT_W-1:0]      drop_cnt_q;

   logic [NS-1:0]         in_msk;
   logic [DATA_WIDTH-1:0] cmp_dat;
   logic [KW-1:0]         cmp_k;
   logic                  fire;
   logic                  s1_adv;
   logic                  acc;
   logic [LW-1:0]         base;
   int                    shamt;
   logic [BW-1:0]         buf_sh;
   logic [BW-1:0]         cmp_wide;
   logic [BW-1:0]         buf_d;
   logic [LW-1:0]         lvl_d;
   logic [BW-1:0]         buf_pad;
   logic [CNT_W-1:0]      drop_pc;
   logic [CNT_W:0]        drop_sum;
   logic [CNT_W-1:0]      drop_cnt_d;

   rx_fsrc_compactor #(
      .NS (NS),
      .NP (NP)
   ) u_cmp (
      .data_i (s1_dat_q),
      .mask_i (s1_msk_q),
      .data_o (cmp_dat),
      .k_o    (cmp_k)
   );

   always_comb begin
      in_msk = '0;
      for (int i = 0; i < NS; i++) begin
         in_msk[i] = (in_data[i*NP +: NP] == marker);
      end
   end

   assign fire   = out_vld_q && out_ready;
   assign s1_adv = s1_vld_q && ((lvl_q < NS_L) || fire);
   assign acc    = in_valid && in_ready;

   assign in_ready   = resetn && (fsrc_en ? (!fl_busy_q && (!s1_vld_q || s1_adv)) : out_ready);
   assign out_valid  = resetn && (fsrc_en ? out_vld_q : in_valid);
   assign out_data   = !resetn ? '0 : (fsrc_en ? buf_q[DATA_WIDTH-1:0] : in_data);
   assign flush_busy = fl_busy_q;
   assign drop_count = drop_cnt_q;

   // Pop first, then append the compacted samples at the post-pop level.
   always_comb begin
      base     = lvl_q - (fire ? NS_L : '0);
      shamt    = int'(base) * NP;
      buf_sh   = fire ? (buf_q >> DATA_WIDTH) : buf_q;
      cmp_wide = {{DATA_WIDTH{1'b0}}, cmp_dat};
      if (s1_adv) begin
         buf_d = (buf_sh & ~({BW{1'b1}} << shamt)) | (cmp_wide << shamt);
         lvl_d = base + LW'(cmp_k);
      end else begin
         buf_d = buf_sh;
         lvl_d = base;
      end
   end

   always_comb begin
      buf_pad = buf_q;
      for (int i = 0; i < NS; i++) begin
         if (LW'(i) >= lvl_q) begin
            buf_pad[i*NP +: NP] = marker;
         end
      end
   end

   always_comb begin
      drop_pc  = CNT_W'(popcount(MAX_NS'(s1_msk_q)));
      drop_sum = {1'b0, drop_cnt_q} + {1'b0, drop_pc};
      if (drop_clr) begin
         drop_cnt_d = '0;
      end else if (!s1_adv) begin
         drop_cnt_d = drop_cnt_q;
      end else if (drop_sum[CNT_W]) begin
         drop_cnt_d = '1;
      end else begin
         drop_cnt_d = drop_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_vld_q   <= 1'b0;
         s1_dat_q   <= '0;
         s1_msk_q   <= '0;
         buf_q      <= '0;
         lvl_q      <= '0;
         out_vld_q  <= 1'b0;
         fl_st_q    <= FL_IDLE;
         fl_busy_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else if (!fsrc_en) begin
         s1_vld_q  <= 1'b0;
         lvl_q     <= '0;
         out_vld_q <= 1'b0;
         fl_st_q   <= FL_IDLE;
         fl_busy_q <= 1'b0;
         if (drop_clr) begin
            drop_cnt_q <= '0;
         end
      end else begin
         drop_cnt_q <= drop_cnt_d;
         if (acc) begin
            s1_vld_q <= 1'b1;
            s1_dat_q <= in_data;
            s1_msk_q <= in_msk;
         end else if (s1_adv) begin
            s1_vld_q <= 1'b0;
         end
         case (fl_st_q)
            FL_IDLE: begin
               buf_q     <= buf_d;
               lvl_q     <= lvl_d;
               out_vld_q <= (lvl_d >= NS_L);
               if (flush) begin
                  fl_st_q   <= FL_DRAIN;
                  fl_busy_q <= 1'b1;
               end
            end
            FL_DRAIN: begin
               // Only a partial residue with nothing left in S1 becomes a padded beat.
               if (!s1_vld_q && (lvl_q < NS_L)) begin
                  if (lvl_q == '0) begin
                     fl_st_q   <= FL_IDLE;
                     fl_busy_q <= 1'b0;
                  end else begin
                     buf_q     <= buf_pad;
                     out_vld_q <= 1'b1;
                     fl_st_q   <= FL_BEAT;
                  end
               end else begin
                  buf_q     <= buf_d;
                  lvl_q     <= lvl_d;
                  out_vld_q <= (lvl_d >= NS_L);
               end
            end
            FL_BEAT: begin
               if (fire) begin
                  lvl_q     <= '0;
                  out_vld_q <= 1'b0;
                  fl_st_q   <= FL_IDLE;
                  fl_busy_q <= 1'b0;
               end
            end
            default: begin
               fl_st_q   <= FL_IDLE;
               fl_busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
